// File: rtl/synaptic_update_scheduler.sv
// synaptic_update_scheduler
//   Walks every (pre neuron, post word) pair after a training sample:
//   pre count read, then read / wait / write-back of the weight and
//   gradient SRAM words for each post word of the row.
//   While no sweep runs, the weight SRAM serves inference read requests.
//   Optional build macro: SYN_SCHED_SKIP_ZERO_EN skips rows whose pre
//   spike count is zero.
module synaptic_update_scheduler #(
   parameter int unsigned INPUT_NEURON         = 784,
   parameter int unsigned OUTPUT_NEURON        = 256,
   parameter int unsigned POST_NEUR_PARALLEL   = 4,
   parameter int unsigned PRE_NEUR_ADDR_WIDTH  = 10,
   parameter int unsigned POST_NEUR_ADDR_WIDTH = 10,
   parameter int unsigned PRE_NEUR_DATA_WIDTH  = 8,
   parameter int unsigned SYN_ARRAY_ADDR_WIDTH = 16,
   parameter int unsigned UPD_LAT              = 1
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            IS_TRAIN,
   input  logic                            CTRL_TREF_EVENT,
   output logic                            PRE_NEUR_CS,
   output logic [PRE_NEUR_ADDR_WIDTH-1:0]  PRE_NEUR_ADDR,
   input  logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_NEUR_S_CNT,
   output logic                            POST_NEUR_CS,
   output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
   output logic                            CTRL_SYNARRAY_CS,
   output logic                            CTRL_SYNARRAY_WE,
   output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
   output logic                            CTRL_GRAD_ARRAY_CS,
   output logic                            CTRL_GRAD_ARRAY_WE,
   input  logic                            INF_REQ,
   input  logic [SYN_ARRAY_ADDR_WIDTH-1:0] INF_ADDR,
   output logic                            INF_GNT,
   output logic                            BUSY,
   output logic                            DONE,
   output logic                            ERR_OVERRUN
);

   localparam int unsigned POST_WORDS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
   localparam int unsigned WAIT_W     = (UPD_LAT > 2) ? $clog2(UPD_LAT - 1) : 1;

   localparam logic [PRE_NEUR_ADDR_WIDTH-1:0]  LAST_PRE  = PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
   localparam logic [POST_NEUR_ADDR_WIDTH-1:0] LAST_WORD = POST_NEUR_ADDR_WIDTH'(POST_WORDS - 1);
   localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] WORDS_A   = SYN_ARRAY_ADDR_WIDTH'(POST_WORDS);
   localparam logic [WAIT_W-1:0]               WAIT_INIT = WAIT_W'((UPD_LAT > 1) ? UPD_LAT - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE_RD, S_PRE_CHK, S_SYN_RD, S_SYN_WAIT, S_SYN_WR, S_DONE
   } state_t;

   state_t                          state;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre;
   logic [POST_NEUR_ADDR_WIDTH-1:0] word;
   logic [WAIT_W-1:0]               wait_cnt;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]  next_pre;
   logic [SYN_ARRAY_ADDR_WIDTH-1:0] cur_addr;

`ifndef SYN_SCHED_SKIP_ZERO_EN
   logic unused_cnt;
   assign unused_cnt = ^PRE_NEUR_S_CNT;
`endif

   // Shared SRAM address of the current (pre, word) pair and the following row index
   always_comb begin
      next_pre = pre + 1'b1;
      cur_addr = SYN_ARRAY_ADDR_WIDTH'(pre) * WORDS_A + SYN_ARRAY_ADDR_WIDTH'(word);
   end

   // Sweep sequencer and arbiter; every output is set for the state being entered
   always_ff @(posedge CLK) begin
      if (RST) begin
         state                    <= S_IDLE;
         pre                      <= '0;
         word                     <= '0;
         wait_cnt                 <= '0;
         PRE_NEUR_CS              <= 1'b0;
         PRE_NEUR_ADDR            <= '0;
         POST_NEUR_CS             <= 1'b0;
         CTRL_POST_NEURON_ADDRESS <= '0;
         CTRL_SYNARRAY_CS         <= 1'b0;
         CTRL_SYNARRAY_WE         <= 1'b0;
         CTRL_SYNARRAY_ADDR       <= '0;
         CTRL_GRAD_ARRAY_CS       <= 1'b0;
         CTRL_GRAD_ARRAY_WE       <= 1'b0;
         INF_GNT                  <= 1'b0;
         BUSY                     <= 1'b0;
         DONE                     <= 1'b0;
         ERR_OVERRUN              <= 1'b0;
      end else begin
         PRE_NEUR_CS        <= 1'b0;
         POST_NEUR_CS       <= 1'b0;
         CTRL_SYNARRAY_CS   <= 1'b0;
         CTRL_SYNARRAY_WE   <= 1'b0;
         CTRL_GRAD_ARRAY_CS <= 1'b0;
         CTRL_GRAD_ARRAY_WE <= 1'b0;
         INF_GNT            <= 1'b0;
         DONE               <= 1'b0;

         if (BUSY && CTRL_TREF_EVENT)
            ERR_OVERRUN <= 1'b1;

         case (state)
            // The DONE cycle already arbitrates like IDLE, so a waiting
            // inference request is granted right after the DONE pulse.
            S_IDLE, S_DONE: begin
               if (CTRL_TREF_EVENT && IS_TRAIN) begin
                  state         <= S_PRE_RD;
                  pre           <= '0;
                  word          <= '0;
                  BUSY          <= 1'b1;
                  PRE_NEUR_CS   <= 1'b1;
                  PRE_NEUR_ADDR <= '0;
               end else begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  if (INF_REQ) begin
                     INF_GNT            <= 1'b1;
                     CTRL_SYNARRAY_CS   <= 1'b1;
                     CTRL_SYNARRAY_ADDR <= INF_ADDR;
                  end
               end
            end

            S_PRE_RD: state <= S_PRE_CHK;

            S_PRE_CHK: begin
`ifdef SYN_SCHED_SKIP_ZERO_EN
               if (PRE_NEUR_S_CNT == '0) begin
                  if (pre == LAST_PRE) begin
                     state <= S_DONE;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                  end else begin
                     pre           <= next_pre;
                     state         <= S_PRE_RD;
                     PRE_NEUR_CS   <= 1'b1;
                     PRE_NEUR_ADDR <= next_pre;
                  end
               end else
`endif
               begin
                  state                    <= S_SYN_RD;
                  POST_NEUR_CS             <= 1'b1;
                  CTRL_SYNARRAY_CS         <= 1'b1;
                  CTRL_GRAD_ARRAY_CS       <= 1'b1;
                  CTRL_SYNARRAY_ADDR       <= cur_addr;
                  CTRL_POST_NEURON_ADDRESS <= word;
               end
            end

            // The address register is left untouched so the write-back hits the read address
            S_SYN_RD: begin
               if (UPD_LAT > 1) begin
                  state    <= S_SYN_WAIT;
                  wait_cnt <= WAIT_INIT;
               end else begin
                  state              <= S_SYN_WR;
                  CTRL_SYNARRAY_CS   <= 1'b1;
                  CTRL_SYNARRAY_WE   <= 1'b1;
                  CTRL_GRAD_ARRAY_CS <= 1'b1;
                  CTRL_GRAD_ARRAY_WE <= 1'b1;
               end
            end

            S_SYN_WAIT: begin
               if (wait_cnt == '0) begin
                  state              <= S_SYN_WR;
                  CTRL_SYNARRAY_CS   <= 1'b1;
                  CTRL_SYNARRAY_WE   <= 1'b1;
                  CTRL_GRAD_ARRAY_CS <= 1'b1;
                  CTRL_GRAD_ARRAY_WE <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end

            S_SYN_WR: begin
               if (word == LAST_WORD) begin
                  word <= '0;
                  if (pre == LAST_PRE) begin
                     state <= S_DONE;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                  end else begin
                     pre           <= next_pre;
                     state         <= S_PRE_RD;
                     PRE_NEUR_CS   <= 1'b1;
                     PRE_NEUR_ADDR <= next_pre;
                  end
               end else begin
                  word                     <= word + 1'b1;
                  state                    <= S_SYN_RD;
                  POST_NEUR_CS             <= 1'b1;
                  CTRL_SYNARRAY_CS         <= 1'b1;
                  CTRL_GRAD_ARRAY_CS       <= 1'b1;
                  CTRL_SYNARRAY_ADDR       <= cur_addr + 1'b1;
                  CTRL_POST_NEURON_ADDRESS <= word + 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_synaptic_update_scheduler.sv
// Bench for synaptic_update_scheduler (4 pre x 2 post words, UPD_LAT=1).
// A timeline model fills per-cycle expected outputs; one negedge process
// compares every output against it each cycle.
module tb_synaptic_update_scheduler;

   localparam int NI    = 4;
   localparam int NO    = 8;
   localparam int PAR   = 4;
   localparam int PW    = NO / PAR;
   localparam int L     = 1;
   localparam int MAXC  = 1024;
   localparam int NEVER = 1 << 30;

   // flag bit positions: pre_cs post_cs syn_cs syn_we grad_cs grad_we gnt busy done err
   localparam logic [9:0] F_PRE   = 10'b10_0000_0000;
   localparam logic [9:0] F_POST  = 10'b01_0000_0000;
   localparam logic [9:0] F_SYN   = 10'b00_1000_0000;
   localparam logic [9:0] F_SYNWE = 10'b00_0100_0000;
   localparam logic [9:0] F_GRAD  = 10'b00_0010_0000;
   localparam logic [9:0] F_GRWE  = 10'b00_0001_0000;
   localparam logic [9:0] F_GNT   = 10'b00_0000_1000;
   localparam logic [9:0] F_BUSY  = 10'b00_0000_0100;
   localparam logic [9:0] F_DONE  = 10'b00_0000_0010;

   logic        clk, rst, is_train, tref, inf_req, inf_gnt;
   logic        pre_cs, post_cs, syn_cs, syn_we, grad_cs, grad_we, busy, done, err;
   logic [9:0]  pre_addr, post_addr;
   logic [7:0]  pre_cnt;
   logic [15:0] syn_addr, inf_addr;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   logic check_en = 1'b0;
   int err_set = NEVER;
   int err_clr = NEVER;

   logic [9:0]  e_flags [MAXC];
   logic [15:0] e_addr  [MAXC];
   logic [9:0]  e_pre   [MAXC];
   logic [9:0]  e_post  [MAXC];
   logic [7:0]  cnt_mem [NI];

   synaptic_update_scheduler #(
      .INPUT_NEURON(NI), .OUTPUT_NEURON(NO), .POST_NEUR_PARALLEL(PAR), .UPD_LAT(L)
   ) dut (
      .CLK(clk), .RST(rst), .IS_TRAIN(is_train), .CTRL_TREF_EVENT(tref),
      .PRE_NEUR_CS(pre_cs), .PRE_NEUR_ADDR(pre_addr), .PRE_NEUR_S_CNT(pre_cnt),
      .POST_NEUR_CS(post_cs), .CTRL_POST_NEURON_ADDRESS(post_addr),
      .CTRL_SYNARRAY_CS(syn_cs), .CTRL_SYNARRAY_WE(syn_we), .CTRL_SYNARRAY_ADDR(syn_addr),
      .CTRL_GRAD_ARRAY_CS(grad_cs), .CTRL_GRAD_ARRAY_WE(grad_we),
      .INF_REQ(inf_req), .INF_ADDR(inf_addr), .INF_GNT(inf_gnt),
      .BUSY(busy), .DONE(done), .ERR_OVERRUN(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   // pre spike-count memory: data appears the cycle after the strobe and is held
   initial begin
      logic [9:0] a;
      pre_cnt = '0;
      forever begin
         @(negedge clk);
         if (pre_cs === 1'b1) begin
            a = pre_addr;
            @(posedge clk);
            #1;
            pre_cnt = cnt_mem[a[1:0]];
         end
      end
   end

   // Timeline of one sweep whose TREF is sampled at the end of cycle s
   task automatic model_sweep(input int s, output int d);
      int c;
      bit skip;
      c = s + 1;
      for (int r = 0; r < NI; r++) begin
         e_flags[c] |= F_PRE;
         e_pre[c] = 10'(r);
         skip = 1'b0;
`ifdef SYN_SCHED_SKIP_ZERO_EN
         skip = (cnt_mem[r] == 0);
`endif
         if (skip) begin
            c += 2;
         end else begin
            for (int w = 0; w < PW; w++) begin
               int rd, wr;
               rd = c + 2 + w * (1 + L);
               wr = rd + L;
               e_flags[rd] |= F_POST | F_SYN | F_GRAD;
               e_addr[rd]  = 16'(r * PW + w);
               e_post[rd]  = 10'(w);
               e_flags[wr] |= F_SYN | F_SYNWE | F_GRAD | F_GRWE;
               e_addr[wr]  = 16'(r * PW + w);
            end
            c += 2 + PW * (1 + L);
         end
      end
      for (int k = s + 1; k < c; k++) e_flags[k] |= F_BUSY;
      e_flags[c] |= F_DONE;
      d = c;
   endtask

   task automatic model_inf(input int c, input logic [15:0] a);
      e_flags[c + 1] |= F_SYN | F_GNT;
      e_addr[c + 1] = a;
   endtask

   task automatic model_reset(input int c);
      for (int k = c; k < MAXC; k++) e_flags[k] = '0;
      err_clr = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   task automatic at_neg(input int n);
      goto(n);
      @(negedge clk);
   endtask

   // cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         logic [9:0] want;
         want = e_flags[cyc];
         if (cyc >= err_set && cyc < err_clr) want[0] = 1'b1;
         check("flags", 32'({pre_cs, post_cs, syn_cs, syn_we, grad_cs, grad_we,
                              inf_gnt, busy, done, err}), 32'(want));
         if (want[7]) check("syn_addr", 32'(syn_addr), 32'(e_addr[cyc]));
         if (want[9]) check("pre_addr", 32'(pre_addr), 32'(e_pre[cyc]));
         if (want[8]) check("post_addr", 32'(post_addr), 32'(e_post[cyc]));
      end
   end

   initial begin
      int s, d, exp_len;
      rst = 1'b1; is_train = 1'b0; tref = 1'b0; inf_req = 1'b0; inf_addr = '0;
      for (int k = 0; k < MAXC; k++) begin
         e_flags[k] = '0; e_addr[k] = '0; e_pre[k] = '0; e_post[k] = '0;
      end
      cnt_mem[0] = 8'd5; cnt_mem[1] = 8'd0; cnt_mem[2] = 8'd2; cnt_mem[3] = 8'd7;

      tick();
      check_en = 1'b1;
      at_neg(2);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      goto(3);
      rst = 1'b0;

      // full sweep
      s = 5;
      goto(s);
      tref = 1'b1; is_train = 1'b1;
      model_sweep(s, d);
      tick();
      tref = 1'b0;
`ifdef SYN_SCHED_SKIP_ZERO_EN
      exp_len = 21;
`else
      exp_len = 25;
`endif
      check("sweep_len", 32'(d - s), 32'(exp_len));
      at_neg(s + 3);
      check("rd0_addr", 32'(syn_addr), 32'd0);
      check("rd0_we", 32'(syn_we), 32'd0);
      at_neg(s + 4);
      check("wr0_we", 32'({syn_we, grad_we}), 32'b11);
      at_neg(d - 1);
      check("busy_before_done", 32'(busy), 32'd1);
      at_neg(d);
      check("done_pulse", 32'({done, busy}), 32'b10);

      // TREF outside training: ignored
      s = d + 3;
      goto(s);
      tref = 1'b1; is_train = 1'b0;
      tick();
      tref = 1'b0;
      at_neg(s + 2);
      check("notrain_idle", 32'({busy, syn_cs, pre_cs}), 32'd0);

      // held inference request: a grant every cycle
      s = s + 6;
      goto(s);
      inf_req = 1'b1; inf_addr = 16'd5;
      for (int c = s; c < s + 5; c++) model_inf(c, 16'd5);
      at_neg(s + 1);
      check("inf_gnt", 32'({inf_gnt, syn_cs, syn_we, grad_cs}), 32'b1100);
      check("inf_addr", 32'(syn_addr), 32'd5);
      goto(s + 5);
      inf_req = 1'b0;

      // inference request colliding with TREF: sweep first
      s = s + 8;
      goto(s);
      tref = 1'b1; is_train = 1'b1; inf_req = 1'b1; inf_addr = 16'd9;
      model_sweep(s, d);
      model_inf(d, 16'd9);
      tick();
      tref = 1'b0;
      at_neg(d);
      check("collide_gnt_at_done", 32'(inf_gnt), 32'd0);
      goto(d + 1);
      inf_req = 1'b0;
      at_neg(d + 1);
      check("collide_gnt_after", 32'(inf_gnt), 32'd1);

      // TREF during a sweep
      s = d + 4;
      goto(s);
      tref = 1'b1;
      model_sweep(s, d);
      tick();
      tref = 1'b0;
      goto(s + 10);
      tref = 1'b1;
      err_set = s + 11;
      at_neg(s + 10);
      check("overrun_before", 32'(err), 32'd0);
      goto(s + 11);
      tref = 1'b0;
      at_neg(s + 11);
      check("overrun_set", 32'(err), 32'd1);

      // reset in the middle of a sweep, then restart
      s = d + 3;
      goto(s);
      tref = 1'b1;
      model_sweep(s, d);
      tick();
      tref = 1'b0;
      goto(s + 9);
      rst = 1'b1;
      model_reset(s + 10);
      tick();
      rst = 1'b0;
      at_neg(s + 10);
      check("midreset_outs", 32'({busy, syn_cs, syn_we, err}), 32'd0);
      s = s + 12;
      goto(s);
      tref = 1'b1;
      model_sweep(s, d);
      tick();
      tref = 1'b0;
      at_neg(s + 3);
      check("restart_addr", 32'(syn_addr), 32'd0);

`ifdef SYN_SCHED_SKIP_ZERO_EN
      // zero-count rows skipped
      cnt_mem[0] = 8'd0; cnt_mem[1] = 8'd3; cnt_mem[2] = 8'd0; cnt_mem[3] = 8'd1;
      s = d + 3;
      goto(s);
      tref = 1'b1;
      model_sweep(s, d);
      tick();
      tref = 1'b0;
      check("skip_len", 32'(d - s), 32'd17);
      at_neg(s + 3);
      check("skip_row1_pre", 32'({pre_cs, pre_addr}), 32'({1'b1, 10'd1}));
      at_neg(s + 5);
      check("skip_row1_addr", 32'(syn_addr), 32'd2);
`endif

      goto(d + 4);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
